// File: rtl/data_memory_stage_if.sv
// data_memory_stage_if: request, response and debug-peek signals of the MEM-stage data memory
interface data_memory_stage_if #(
   parameter int IDX_W = 10
);
   logic             Enable;
   logic             RW;
   logic [1:0]       Size;
   logic             SE;
   logic [31:0]      Address;
   logic [31:0]      DataIn;
   logic [31:0]      DataOut;
   logic             Valid;
   logic             MisalignErr;
   logic [IDX_W-1:0] DbgAddr;
   logic [31:0]      DbgWord;
   modport master (
      output Enable, RW, Size, SE, Address, DataIn, DbgAddr,
      input  DataOut, Valid, MisalignErr, DbgWord
   );
   modport slave (
      input  Enable, RW, Size, SE, Address, DataIn, DbgAddr,
      output DataOut, Valid, MisalignErr, DbgWord
   );
endinterface

// File: rtl/data_memory_stage.sv
// data_memory_stage: big-endian byte-addressed data memory with registered, extended loads
module data_memory_stage #(
   parameter int DEPTH_BYTES = 1024,
   parameter int IDX_W = 10
) (
   input logic                clk,
   input logic                reset,
   data_memory_stage_if.slave bus
);
   logic [7:0]       mem [DEPTH_BYTES];
   logic [IDX_W-1:0] idx, wa, da;
   logic [1:0]       off;
   logic [31:0]      word, ld;
   logic [7:0]       bsel;
   logic [15:0]      hsel;
   logic             mis;
   logic [3:0]       we;
   logic [7:0]       wd [4];
   logic             unused_bits;
   assign idx = bus.Address[IDX_W-1:0];
   assign off = idx[1:0];
   assign wa = {idx[IDX_W-1:2], 2'b00};
   assign da = {bus.DbgAddr[IDX_W-1:2], 2'b00};
   assign unused_bits = ^{bus.Address[31:IDX_W], bus.DbgAddr[1:0]};
   assign bus.DbgWord = {mem[da], mem[da | IDX_W'(1)], mem[da | IDX_W'(2)], mem[da | IDX_W'(3)]};
   // fetch the containing aligned word, then pick and extend the addressed byte/halfword
   always_comb begin
      word = {mem[wa], mem[wa | IDX_W'(1)], mem[wa | IDX_W'(2)], mem[wa | IDX_W'(3)]};
      bsel = 8'(word >> {~off, 3'b000});
      hsel = off[1] ? word[15:0] : word[31:16];
      mis = bus.Size == 2'b00 ? 1'b0 : bus.Size == 2'b01 ? off[0] : |off;
      ld = bus.Size == 2'b00 ? {{24{bus.SE & bsel[7]}}, bsel}
         : bus.Size == 2'b01 ? {{16{bus.SE & hsel[15]}}, hsel} : word;
   end
   // per-lane write enables and big-endian lane data; misaligned stores write nothing
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         we[k] = bus.Enable & bus.RW & ~mis &
                 (bus.Size == 2'b00 ? off == 2'(k) : bus.Size == 2'b01 ? off[1] == k[1] : 1'b1);
         wd[k] = bus.Size == 2'b00 ? bus.DataIn[7:0]
               : bus.Size == 2'b01 ? (k[0] ? bus.DataIn[7:0] : bus.DataIn[15:8])
               : bus.DataIn[8*(3-k) +: 8];
      end
   end
   // memory write port; array is never reset so contents survive reset
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (we[k]) mem[wa | IDX_W'(k)] <= wd[k];
   end
   // registered response: pulse Valid per request, zero data on misalignment, hold on stores/idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.DataOut     <= '0;
         bus.Valid       <= 1'b0;
         bus.MisalignErr <= 1'b0;
      end else begin
         bus.Valid       <= bus.Enable;
         bus.MisalignErr <= bus.Enable & mis;
         if (bus.Enable & mis) bus.DataOut <= '0;
         else if (bus.Enable & ~bus.RW) bus.DataOut <= ld;
      end
   end
endmodule

// File: tb/tb_data_memory_stage.sv
// tb_data_memory_stage: directed plan plus randomized accesses checked against a byte-array model
module tb_data_memory_stage;
   localparam int DEPTH = 1024;
   localparam int IW = 10;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int passed = 0;
   logic [7:0] m [DEPTH];
   logic [31:0] exp_out = '0;
   data_memory_stage_if #(.IDX_W(IW)) bus();
   data_memory_stage #(.DEPTH_BYTES(DEPTH), .IDX_W(IW)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] peek(input int a);
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++) v = (v << 8) | 32'(m[(a & ~3) + i]);
      return v;
   endfunction

   task automatic access(input bit rw, input logic [1:0] size, input bit se,
                         input logic [31:0] addr, input logic [31:0] data, input string tag);
      int n = size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4;
      int a = int'(addr[IW-1:0]);
      bit bad = (a % n) != 0;
      logic [31:0] v = '0;
      @(negedge clk);
      bus.Enable = 1'b1; bus.RW = rw; bus.Size = size; bus.SE = se;
      bus.Address = addr; bus.DataIn = data;
      @(posedge clk);
      #1;
      if (bad) exp_out = '0;
      else if (rw) begin
         for (int i = 0; i < n; i++) m[a + i] = 8'(data >> (8 * (n - 1 - i)));
      end else begin
         for (int i = 0; i < n; i++) v = (v << 8) | 32'(m[a + i]);
         if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
         exp_out = v;
      end
      check({tag, " valid"}, 32'(bus.Valid), 32'd1);
      check({tag, " misalign"}, 32'(bus.MisalignErr), 32'(bad));
      check({tag, " data"}, bus.DataOut, exp_out);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.Enable = 1'b0;
      @(posedge clk);
      #1;
      check("idle valid", 32'(bus.Valid), 32'd0);
      check("idle misalign", 32'(bus.MisalignErr), 32'd0);
      check("idle data", bus.DataOut, exp_out);
   endtask

   task automatic dbg(input int a, input string tag);
      bus.DbgAddr = IW'(a);
      #1;
      check(tag, bus.DbgWord, peek(a));
   endtask

   initial begin
      bus.Enable = 1'b0; bus.RW = 1'b0; bus.Size = 2'b00; bus.SE = 1'b0;
      bus.Address = '0; bus.DataIn = '0; bus.DbgAddr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset data", bus.DataOut, 32'd0);
      check("reset valid", 32'(bus.Valid), 32'd0);
      check("reset misalign", 32'(bus.MisalignErr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < DEPTH; a += 4) access(1'b1, 2'b10, 1'b0, 32'(a), $urandom, "fill");
      access(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, "st w");
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld w");
      check("ld w const", bus.DataOut, 32'hA1B2C3D4);
      dbg(16, "dbg 10");
      check("dbg 10 const", bus.DbgWord, 32'hA1B2C3D4);
      access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, "ld bs");
      check("ld bs const", bus.DataOut, 32'hFFFFFFA1);
      access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "ld bz");
      check("ld bz const", bus.DataOut, 32'h000000D4);
      access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "ld hs");
      check("ld hs const", bus.DataOut, 32'hFFFFC3D4);
      access(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "ld hz");
      check("ld hz const", bus.DataOut, 32'h0000C3D4);
      access(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456EE, "st b");
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "raw");
      check("raw const", bus.DataOut, 32'hA1EEC3D4);
      access(1'b1, 2'b10, 1'b0, 32'h13, 32'hFFFFFFFF, "mis st");
      check("mis st const", bus.DataOut, 32'd0);
      dbg(16, "dbg after mis");
      check("dbg after mis const", bus.DbgWord, 32'hA1EEC3D4);
      access(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, "mis ld");
      idle();
      access(1'b1, 2'b10, 1'b0, 32'h410, 32'hCAFEF00D, "wrap st");
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "wrap ld");
      check("wrap const", bus.DataOut, 32'hCAFEF00D);
      @(negedge clk);
      bus.Enable = 1'b1; bus.RW = 1'b0; bus.Size = 2'b10; bus.Address = 32'h10;
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst valid", 32'(bus.Valid), 32'd0);
      check("rst data", bus.DataOut, 32'd0);
      check("rst misalign", 32'(bus.MisalignErr), 32'd0);
      exp_out = '0;
      @(negedge clk);
      bus.Enable = 1'b0;
      reset = 1'b0;
      idle();
      access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "post rst");
      check("post rst const", bus.DataOut, 32'hCAFEF00D);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) idle();
         else access(1'(|$urandom_range(0, 2)), 2'($urandom), 1'($urandom), $urandom, $urandom, "rnd");
         if (i % 8 == 0) dbg(int'($urandom_range(0, DEPTH - 1)), "rnd dbg");
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
- Byte-addressed data memory for the MEM stage.
- Consumes the ALU result as an effective address, plus store data and size/sign controls from the EX/MEM pipeline register.
- Performs big-endian byte, halfword and word loads and stores.
- Load data is registered: valid one cycle after the request, then presented to the writeback mux.

Parameters:
DEPTH_BYTES, 1024, memory size in bytes; must be a power of two, minimum 4
IDX_W, 10, address index width, equal to log2(DEPTH_BYTES)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
Enable  input  1  request strobe; one access per cycle when high
RW  input  1  1 = store, 0 = load
Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
SE  input  1  loads only: 1 = sign-extend, 0 = zero-extend
Address  input  32  effective address from ALU Out
DataIn  input  32  store data; byte uses [7:0], halfword uses [15:0]
DataOut  output  32  registered load result
Valid  output  1  one-cycle pulse: the request accepted last cycle has completed
MisalignErr  output  1  one-cycle pulse alongside Valid: last request was misaligned
DbgAddr  input  IDX_W  testbench word-peek address (bits [1:0] ignored)
DbgWord  output  32  combinational big-endian word at DbgAddr aligned down

Behaviour:
- Reset (asynchronous, active-high):
  - Reset values: DataOut=0, Valid=0, MisalignErr=0.
  - Memory array contents are not cleared.
  - A request whose completion edge is preempted by reset produces no Valid.
- Indexing:
  - Index = Address[IDX_W-1:0]; upper bits are ignored (aliasing/wrap modulo DEPTH_BYTES).
- Byte ordering (big-endian):
  - Word at aligned index i: mem[i] -> [31:24], mem[i+1] -> [23:16], mem[i+2] -> [15:8], mem[i+3] -> [7:0].
  - Halfword at i: mem[i] -> [15:8], mem[i+1] -> [7:0].
- Alignment:
  - Halfword is misaligned if Address[0]=1.
  - Word or reserved size is misaligned if Address[1:0]!=00.
  - Byte accesses are never misaligned.
- Cycle t, Enable=1, aligned store:
  - Bytes are written at the rising edge ending cycle t.
  - In cycle t+1: Valid=1, MisalignErr=0, DataOut holds its previous value.
- Cycle t, Enable=1, aligned load:
  - Data is read at the rising edge ending cycle t.
  - In cycle t+1: DataOut = the extended value, Valid=1.
- Extension:
  - Byte: SE=1 replicates bit 7; SE=0 zero-fills.
  - Halfword: SE=1 replicates bit 15; SE=0 zero-fills.
  - Word: SE ignored.
- Misaligned request:
  - Memory is not written.
  - In cycle t+1: DataOut=0, Valid=1, MisalignErr=1.
- Enable=0: the next cycle has Valid=0, MisalignErr=0, and DataOut holds.
- Back-to-back requests:
  - Accepted every cycle (no stall, no busy).
  - A load in cycle t+1 to an address stored in cycle t returns the new data.
- Timing observability:
  - DbgWord reflects writes immediately after the committing edge.
  - No combinational path from request inputs to DataOut or Valid.
- Implementation: plain reg byte array, inferable as RAM. No reset loop over the array.

Test Plan:
- Store word 0xA1B2C3D4 at 0x10; load word 0x10 -> Valid pulse; DataOut=0xA1B2C3D4; DbgWord(0x10)=0xA1B2C3D4.
- After the above:
  - Load byte 0x10, SE=1 -> 0xFFFFFFA1.
  - Load byte 0x13, SE=0 -> 0x000000D4.
  - Load half 0x12, SE=1 -> 0xFFFFC3D4.
  - Load half 0x12, SE=0 -> 0x0000C3D4.
- Store byte DataIn=0x123456EE at 0x11, then load word 0x10 on the very next cycle -> 0xA1EEC3D4 (read-after-write, only the low byte stored).
- Misaligned cases:
  - Store word 0xFFFFFFFF at 0x13 -> Valid=1, MisalignErr=1, DataOut=0; DbgWord(0x10) unchanged at 0xA1EEC3D4.
  - Load half at 0x11 -> same error pulse.
- Wrap: store word 0xCAFEF00D at 0x00000410 (DEPTH_BYTES=1024) -> load word 0x10 returns 0xCAFEF00D.
- Reset mid-operation:
  - Issue load 0x10; assert reset before the next rising edge -> Valid stays 0 and DataOut=0.
  - After release, load 0x10 returns the previously stored data; memory is preserved.
